// File: rtl/mips32_fetch_queue.sv
// Decoupled instruction-fetch stage: PC generation, synchronous imem requests and a small
// prefetch FIFO of {ir, npc} handed to decode over a valid/ready handshake.
module mips32_fetch_queue #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_ir,
    output logic [ADDR_W-1:0] id_npc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   CreditLimit = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] FullCount   = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] ir_mem  [DEPTH];
    logic [ADDR_W-1:0] npc_mem [DEPTH];

    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    occupancy;
    logic              fifo_empty;

    assign fifo_empty = (count_q == '0);

    // A redirect cycle never transfers: the head is about to be flushed.
    assign id_valid = !fifo_empty && !redirect_valid;
    assign pop      = id_valid && id_ready;
    assign push     = inflight_q && !redirect_valid;

    assign id_ir  = fifo_empty ? '0 : ir_mem[rd_ptr_q];
    assign id_npc = fifo_empty ? '0 : npc_mem[rd_ptr_q];

    // Slots already promised (buffered + in flight) net of this cycle's pop; pop implies count >= 1.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};

    assign issue     = !rst && !halt && !redirect_valid && (occupancy < CreditLimit);
    assign imem_req  = issue;
    assign imem_addr = pc_q;

    always_comb begin
        pc_d            = pc_q;
        inflight_d      = 1'b0;
        inflight_addr_d = inflight_addr_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d            = pc_q + ADDR_W'(1);
                inflight_d      = 1'b1;
                inflight_addr_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
        end
    end

    // Payload storage needs no reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            ir_mem[wr_ptr_q]  <= imem_rdata;
            npc_mem[wr_ptr_q] <= inflight_addr_q + ADDR_W'(1);
        end
    end

    push_never_full_a : assert property (@(posedge clk) disable iff (rst)
        push |-> (count_q != FullCount));

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for mips32_fetch_queue: streaming, back-pressure, redirect, halt, PC wrap
// and mid-stream reset, against a one-cycle-latency memory holding 0x1000_0000 + addr.
module tb_mips32_fetch_queue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              id_valid;
    logic              id_ready;
    logic [DATA_W-1:0] id_ir;
    logic [ADDR_W-1:0] id_npc;

    int n_vec;
    int n_err;

    mips32_fetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC ('0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ir          (id_ir),
        .id_npc         (id_npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial imem_rdata = '0;
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'h1000_0000 + {22'b0, imem_addr};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    // Leaves rst=1 in the current cycle; the caller releases it to start cycle 0.
    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        id_ready = ready;
        next();
        next();
    endtask

    function automatic logic [31:0] word(input int unsigned a);
        return 32'h1000_0000 + (a & 32'h3FF);
    endfunction

    initial begin
        int nreq;
        int ndel;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        id_ready = 1'b1;

        // Streaming with id_ready=1
        do_reset(1'b1);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_ir", id_ir, 32'd0);
        check("rst_npc", 32'(id_npc), 32'd0);
        rst = 1'b0;
        #1;
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", 32'(imem_addr), 32'd0);
        check("c0_valid", 32'(id_valid), 32'd0);
        next();
        check("c1_req", 32'(imem_req), 32'd1);
        check("c1_addr", 32'(imem_addr), 32'd1);
        check("c1_valid", 32'(id_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            next();
            check("strm_valid", 32'(id_valid), 32'd1);
            check("strm_ir", id_ir, word(k));
            check("strm_npc", 32'(id_npc), 32'(k + 1));
        end

        // Back-pressure: exactly DEPTH requests, then lossless drain
        do_reset(1'b0);
        rst = 1'b0;
        #1;
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            if (imem_req) begin
                check("bp_addr", 32'(imem_addr), 32'(nreq));
                nreq++;
            end
            next();
        end
        check("bp_nreq", 32'(nreq), 32'd4);
        check("bp_req_off", 32'(imem_req), 32'd0);
        check("bp_valid", 32'(id_valid), 32'd1);
        check("bp_head_stable", id_ir, word(0));
        id_ready = 1'b1;
        #1;
        check("bp_resume_req", 32'(imem_req), 32'd1);
        check("bp_resume_addr", 32'(imem_addr), 32'd4);
        ndel = 0;
        for (int k = 0; k < 10; k++) begin
            if (id_valid && id_ready) begin
                check("bp_ir", id_ir, word(ndel));
                check("bp_npc", 32'(id_npc), 32'(ndel + 1));
                ndel++;
            end
            next();
        end
        check("bp_ndel", 32'(ndel), 32'd10);

        // Redirect with 3 buffered and 1 in flight
        do_reset(1'b0);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) next();
        check("rd_pre_req", 32'(imem_req), 32'd0);
        check("rd_pre_ir", id_ir, word(0));
        redirect_valid = 1'b1;
        redirect_pc = 10'h200;
        id_ready = 1'b1;
        #1;
        check("rd_valid", 32'(id_valid), 32'd0);
        check("rd_req", 32'(imem_req), 32'd0);
        next();
        redirect_valid = 1'b0;
        #1;
        check("rd_new_req", 32'(imem_req), 32'd1);
        check("rd_new_addr", 32'(imem_addr), 32'h200);
        check("rd_new_valid0", 32'(id_valid), 32'd0);
        next();
        check("rd_new_valid1", 32'(id_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            next();
            check("rd_ir", id_ir, word(32'h200 + k));
            check("rd_npc", 32'(id_npc), 32'h201 + k);
        end

        // Halt at PC=5
        do_reset(1'b1);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) next();
        halt = 1'b1;
        #1;
        check("h_req", 32'(imem_req), 32'd0);
        check("h_ir3", id_ir, word(3));
        next();
        check("h_valid4", 32'(id_valid), 32'd1);
        check("h_ir4", id_ir, word(4));
        check("h_npc4", 32'(id_npc), 32'd5);
        for (int k = 0; k < 5; k++) begin
            next();
            check("h_idle_valid", 32'(id_valid), 32'd0);
            check("h_idle_req", 32'(imem_req), 32'd0);
        end
        halt = 1'b0;
        #1;
        check("h_resume_req", 32'(imem_req), 32'd1);
        check("h_resume_addr", 32'(imem_addr), 32'd5);
        next();
        next();
        check("h_resume_ir", id_ir, word(5));
        check("h_resume_npc", 32'(id_npc), 32'd6);

        // PC wrap at the top of the address space
        do_reset(1'b1);
        rst = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 10'h3FE;
        #1;
        check("w_req_rd", 32'(imem_req), 32'd0);
        next();
        redirect_valid = 1'b0;
        #1;
        check("w_addr0", 32'(imem_addr), 32'h3FE);
        next();
        check("w_addr1", 32'(imem_addr), 32'h3FF);
        next();
        check("w_addr2", 32'(imem_addr), 32'h000);
        check("w_ir0", id_ir, word(32'h3FE));
        check("w_npc0", 32'(id_npc), 32'h3FF);
        next();
        check("w_ir1", id_ir, word(32'h3FF));
        check("w_npc1", 32'(id_npc), 32'h000);
        next();
        check("w_ir2", id_ir, word(0));
        check("w_npc2", 32'(id_npc), 32'h001);

        // Reset mid-stream with count=2 and one fetch in flight
        do_reset(1'b0);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) next();
        check("mr_pre_valid", 32'(id_valid), 32'd1);
        rst = 1'b1;
        id_ready = 1'b1;
        #1;
        check("mr_req_in_rst", 32'(imem_req), 32'd0);
        next();
        rst = 1'b0;
        #1;
        check("mr_valid", 32'(id_valid), 32'd0);
        check("mr_addr", 32'(imem_addr), 32'd0);
        check("mr_req", 32'(imem_req), 32'd1);
        next();
        check("mr_valid1", 32'(id_valid), 32'd0);
        next();
        check("mr_ir", id_ir, word(0));
        check("mr_npc", 32'(id_npc), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips32_fetch_queue.md
Name: mips32_fetch_queue

Overview:
- Instruction-fetch front end for the mips32 pipeline. Generates the fetch PC and issues word reads to a synchronous instruction memory.
- Buffers each returned instruction with its next-PC in a small prefetch FIFO and presents them to the decode stage over a valid/ready handshake.
- Takes branch redirects from EX/MEM: the PC is redirected and all buffered and in-flight fetches are flushed.
- Replaces the direct mem[PC] fetch with a decoupled, stallable stage.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of 2, ≥2)
- ADDR_W, 10, instruction word-address width (1024-word memory)
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDR_W  word address of the request (equals current PC)
- imem_rdata  in  DATA_W  read data, valid exactly 1 cycle after imem_req
- redirect_valid  in  1  taken-branch redirect (EX_MEM branch condition met)
- redirect_pc  in  ADDR_W  branch target word address
- halt  in  1  stop issuing new fetches (HLT seen downstream); level-sensitive
- id_valid  out  1  FIFO head holds a valid instruction
- id_ready  in  1  decode accepts the head this cycle
- id_ir  out  DATA_W  head instruction
- id_npc  out  ADDR_W  head fetch address + 1 (mod 2^ADDR_W)

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous, active-high (rst).
  - rst takes priority over every other input.
- State: PC (ADDR_W bits), FIFO of {ir, npc} with rd/wr pointers and count (0..DEPTH), inflight_q (1 bit) and inflight_addr_q.
- Reset values:
  - PC=RESET_PC, count=0, pointers=0, inflight_q=0.
  - Outputs: imem_req=0, id_valid=0, id_ir=0, id_npc=0.
  - Reset mid-operation discards all buffered and in-flight instructions. The memory response arriving the cycle after reset is ignored.
- Handshake:
  - pop = id_valid && id_ready.
  - id_valid = (count != 0) && !redirect_valid. No transfer occurs in a redirect cycle.
  - id_ir/id_npc are driven from the FIFO head, are stable while id_valid=1 and id_ready=0, and read 0 when count=0.
- Issue rule (combinational):
  - imem_req = !rst && !halt && !redirect_valid && (count + inflight_q − pop < DEPTH).
  - imem_addr = PC.
  - On issue: PC <= PC+1 (wraps 2^ADDR_W−1 → 0), inflight_q <= 1, inflight_addr_q <= PC. Otherwise inflight_q <= 0.
- Response:
  - If inflight_q=1 and no redirect this cycle, push {imem_rdata, inflight_addr_q+1} into the FIFO.
  - The credit check guarantees a push never finds the FIFO full. Push-into-full is an assertion failure.
  - Simultaneous push and pop: count unchanged, both pointers advance. Pop on empty cannot happen (id_valid=0).
- Latency:
  - Reset released at cycle 0: first request issues in cycle 0, data is pushed at cycle 1, and id_valid=1 at cycle 2.
  - Steady state with id_ready=1: one instruction per cycle.
- Redirect (redirect_valid=1):
  - PC <= redirect_pc.
  - FIFO flushed: count=0, pointers reset.
  - inflight_q <= 0; a response returning this cycle is dropped.
  - No request is issued this cycle. Fetching resumes from redirect_pc the next cycle (unless halt).
- Halt:
  - While halt=1 no new requests issue. An in-flight response is still pushed and the FIFO keeps draining to decode.
  - Deasserting halt resumes fetch from the current PC.
  - redirect while halt=1: PC updated and FIFO flushed, no issue.
- Back-pressure:
  - With id_ready=0, fetch continues until count+inflight_q=DEPTH, then imem_req=0.
  - No instruction is lost or duplicated.

Test Plan:
- Reset, imem[i]=0x1000_0000+i, id_ready=1 → imem_req cycle 0 at addr 0; id_valid from cycle 2; id_ir sequence 0x10000000, 0x10000001, … with id_npc 1, 2, …, one per cycle.
- id_ready=0 for 10 cycles after reset → exactly DEPTH=4 requests issued (addr 0..3), imem_req=0 afterwards, count=4. Release id_ready → outputs addr 0..3 then 4.. continuous, none duplicated.
- Steady streaming, redirect_valid=1 with redirect_pc=0x200 while 3 entries are buffered and 1 in flight → id_valid=0 that cycle; next cycle imem_addr=0x200; first delivered id_npc=0x201; no pre-redirect instruction ever appears.
- halt=1 at PC=5 with id_ready=1 → in-flight addr 4 still delivered, then id_valid=0 and imem_req=0 indefinitely. halt=0 → fetch resumes at addr 5.
- PC starts at 0x3FE (via redirect) → fetch 0x3FE, 0x3FF, 0x000; id_npc 0x3FF, 0x000, 0x001.
- rst asserted mid-stream with count=2 and inflight_q=1 → next cycle id_valid=0, PC=RESET_PC, and the late memory response is not enqueued.
